// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave backed by a byte-writable word memory.
// Write and read channels run independently, one outstanding burst each.
module axi4_slave_mem #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ID_W   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB  = AXI_DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]            SIZE_OK = 3'(LSB);
  localparam logic [AXI_ADDR_W-1:0] STEP    = AXI_ADDR_W'(NB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [AXI_DATA_W-1:0] r_mem [MEM_DEPTH];

  function automatic logic in_range(input logic [AXI_ADDR_W-1:0] a);
    return (a >> LSB) < AXI_ADDR_W'(MEM_DEPTH);
  endfunction

  function automatic logic [MW-1:0] widx(input logic [AXI_ADDR_W-1:0] a);
    return MW'(a >> LSB);
  endfunction

  // Unsupported size or WRAP/reserved burst type poisons the whole burst.
  function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_OK) || burst[1];
  endfunction

  // ---------------- write channel ----------------
  wstate_t               r_wstate, w_wstate_nxt;
  logic [AXI_ID_W-1:0]   r_awid;
  logic [AXI_ADDR_W-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wfixed, r_wbad;
  logic [1:0]            r_bresp;
  logic                  w_aw_hs, w_w_hs, w_wfinal, w_win, w_wen;

  assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_w_hs   = s_axi_wvalid && s_axi_wready;
  assign w_wfinal = (r_wcnt == r_wlen);
  assign w_win    = in_range(r_waddr);
  assign w_wen    = w_w_hs && !r_wbad && w_win;
  assign s_axi_bid   = r_awid;
  assign s_axi_bresp = r_bresp;

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_wfinal) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write burst context, beat address/count and accumulated response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awid   <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wfixed <= 1'b0;
      r_wbad   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_awid   <= s_axi_awid;
        r_waddr  <= s_axi_awaddr;
        r_wlen   <= s_axi_awlen;
        r_wcnt   <= '0;
        r_wfixed <= (s_axi_awburst == 2'b00);
        r_wbad   <= bad_cmd(s_axi_awsize, s_axi_awburst);
        r_bresp  <= bad_cmd(s_axi_awsize, s_axi_awburst) ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (!r_wfixed) r_waddr <= r_waddr + STEP;
        // SLVERR is sticky and outranks DECERR once latched.
        if (s_axi_wlast != w_wfinal)                   r_bresp <= RESP_SLVERR;
        else if (!w_win && r_bresp != RESP_SLVERR)     r_bresp <= RESP_DECERR;
      end
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) r_mem[widx(r_waddr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_rstate, w_rstate_nxt;
  logic [AXI_ID_W-1:0]   r_arid;
  logic [AXI_ADDR_W-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rfixed, r_rbad;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  w_ar_hs, w_r_hs, w_fetch, w_fbad, w_flast;
  logic [AXI_ADDR_W-1:0] w_faddr;

  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_r_hs  = s_axi_rvalid && s_axi_rready;
  // Each beat is fetched into the output register on the edge that
  // accepts the previous beat (or the AR), so the data holds under stall.
  assign w_fetch = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_faddr = (r_rstate == R_IDLE) ? s_axi_araddr
                 : (r_rfixed ? r_raddr : r_raddr + STEP);
  assign w_fbad  = (r_rstate == R_IDLE) ? bad_cmd(s_axi_arsize, s_axi_arburst) : r_rbad;
  assign w_flast = (r_rstate == R_IDLE) ? (s_axi_arlen == 8'd0)
                 : ((r_rcnt + 8'd1) == r_rlen);
  assign s_axi_rid   = r_arid;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign s_axi_rlast = r_rlast;

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read burst context and registered beat data/response/last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arid   <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rfixed <= 1'b0;
      r_rbad   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rlast  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_arid   <= s_axi_arid;
        r_rlen   <= s_axi_arlen;
        r_rcnt   <= '0;
        r_rfixed <= (s_axi_arburst == 2'b00);
        r_rbad   <= bad_cmd(s_axi_arsize, s_axi_arburst);
      end
      if (w_r_hs && !r_rlast) r_rcnt <= r_rcnt + 8'd1;
      if (w_fetch) begin
        r_raddr <= w_faddr;
        r_rlast <= w_flast;
        if (w_fbad) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end else if (!in_range(w_faddr)) begin
          r_rdata <= '0;
          r_rresp <= RESP_DECERR;
        end else begin
          r_rdata <= r_mem[widx(w_faddr)];
          r_rresp <= RESP_OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem: randomized self-checking bench with a behavioural memory model.
module tb_axi4_slave_mem;
  localparam int AW = 32, DW = 128, IW = 4, DEPTH = 1024, NB = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [NB-1:0] s_axi_wstrb;

  always #5 clk = ~clk;

  axi4_slave_mem #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int checks = 0, failures = 0;

  // Reference memory and burst buffers.
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] wd [256];
  logic [NB-1:0] ws [256];
  logic          wl [256];
  logic [DW-1:0] rd [256], er_d [256];
  logic [1:0]    rr [256], er_r [256];
  logic          rl [256];
  logic [IW-1:0] ri [256];
  logic [1:0]    o_bresp;
  logic [IW-1:0] o_bid;
  logic          o_wlat, o_blat, o_bhold, o_rlat, o_rhold;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int i,
                                              input logic [1:0] burst);
    return (burst == 2'b00) ? base : base + AW'(i) * AW'(NB);
  endfunction

  function automatic logic [1:0] beat_resp(input logic [AW-1:0] base, input int i,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] a;
    if (size != 3'd4 || burst > 2'd1) return 2'b10;
    a = beat_addr(base, i, burst);
    if ((a >> 4) >= AW'(DEPTH)) return 2'b11;
    return 2'b00;
  endfunction

  // Apply a write burst (wd/ws/wl) to the model and give the expected bresp.
  task automatic mdl_write(input logic [AW-1:0] base, input int len, input logic [2:0] size,
                           input logic [1:0] burst, output logic [1:0] eb);
    logic slv, dec;
    logic [AW-1:0] a;
    logic [1:0] r;
    slv = (size != 3'd4) || (burst > 2'd1);
    dec = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (wl[i] != (i == len)) slv = 1'b1;
      a = beat_addr(base, i, burst);
      r = beat_resp(base, i, size, burst);
      if (r == 2'b11) dec = 1'b1;
      if (r == 2'b00)
        for (int b = 0; b < NB; b++)
          if (ws[i][b]) mdl[int'(a >> 4)][b*8 +: 8] = wd[i][b*8 +: 8];
    end
    eb = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endtask

  // Expected beats of a read burst into er_d/er_r.
  task automatic exp_read(input logic [AW-1:0] base, input int len, input logic [2:0] size,
                          input logic [1:0] burst);
    for (int i = 0; i <= len; i++) begin
      er_r[i] = beat_resp(base, i, size, burst);
      er_d[i] = (er_r[i] == 2'b00) ? mdl[int'(beat_addr(base, i, burst) >> 4)] : '0;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id, input bit gaps);
    int n;
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len[7:0];
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awid = id;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    if (!s_axi_awready) begin
      checks++; failures++;
      $display("FAIL timeout_aw got=no_awready exp=awready");
      s_axi_awvalid = 1'b0;
      return;
    end
    tick();
    s_axi_awvalid = 1'b0;
    o_wlat = s_axi_wready;
    for (int i = 0; i <= len; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; tick(); end
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = wl[i];
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      if (!s_axi_wready) begin
        checks++; failures++;
        $display("FAIL timeout_w beat=%0d got=no_wready exp=wready", i);
        s_axi_wvalid = 1'b0;
        return;
      end
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    o_blat = s_axi_bvalid; o_bresp = s_axi_bresp; o_bid = s_axi_bid; o_bhold = 1'b1;
    repeat ($urandom_range(0, 2)) begin
      tick();
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== o_bresp || s_axi_bid !== o_bid) o_bhold = 1'b0;
    end
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    if (!s_axi_bvalid) begin
      checks++; failures++;
      $display("FAIL timeout_b got=no_bvalid exp=bvalid");
    end
    o_bresp = s_axi_bresp; o_bid = s_axi_bid;
    tick();
    s_axi_bready = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id, input int mode);
    int n, k;
    bit stalled;
    logic [DW-1:0] hd;
    logic [1:0] hr;
    logic hl;
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len[7:0];
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arid = id;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    if (!s_axi_arready) begin
      checks++; failures++;
      $display("FAIL timeout_ar got=no_arready exp=arready");
      s_axi_arvalid = 1'b0;
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;
    o_rlat = s_axi_rvalid; o_rhold = 1'b1;
    k = 0; n = 0; stalled = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    while (k <= len && n < 2000) begin
      if (s_axi_rvalid && stalled && (s_axi_rdata !== hd || s_axi_rresp !== hr || s_axi_rlast !== hl))
        o_rhold = 1'b0;
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (n % 2 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
      stalled = s_axi_rvalid && !s_axi_rready;
      if (s_axi_rvalid && s_axi_rready) begin
        rd[k] = s_axi_rdata; rr[k] = s_axi_rresp; rl[k] = s_axi_rlast; ri[k] = s_axi_rid;
        k++;
      end
      tick();
      n++;
    end
    s_axi_rready = 1'b0;
    if (k <= len) begin
      checks++; failures++;
      $display("FAIL timeout_r got=%0d_beats exp=%0d_beats", k, len + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b%b exp=11", s_axi_awready, s_axi_arready); end
    checks++; if ({s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 4'b0000) begin failures++;
      $display("FAIL reset_valids got=%b%b%b%b exp=0000", s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast); end
    checks++; if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin failures++;
      $display("FAIL reset_resp got=%b/%b exp=00/00", s_axi_bresp, s_axi_rresp); end
    checks++; if (s_axi_bid !== '0 || s_axi_rid !== '0) begin failures++;
      $display("FAIL reset_ids got=%h/%h exp=0/0", s_axi_bid, s_axi_rid); end
    checks++; if (s_axi_rdata !== '0) begin failures++;
      $display("FAIL reset_rdata got=%h exp=0", s_axi_rdata); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Fill the whole memory with four maximum-length bursts.
  task automatic test_preload();
    logic [1:0] eb;
    for (int q = 0; q < 4; q++) begin
      for (int j = 0; j < 256; j++) begin
        wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = '1; wl[j] = (j == 255);
      end
      mdl_write(AW'(q * 256 * NB), 255, 3'd4, 2'b01, eb);
      do_write(AW'(q * 256 * NB), 255, 3'd4, 2'b01, IW'(q + 1), 1'b0);
      checks++; if (o_bresp !== eb || o_bid !== IW'(q + 1)) begin failures++;
        $display("FAIL preload_b q=%0d got=%b/%h exp=%b/%h", q, o_bresp, o_bid, eb, IW'(q + 1)); end
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] eb;
    for (int j = 0; j < 4; j++) begin
      wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = '1; wl[j] = (j == 3);
    end
    mdl_write(32'h100, 3, 3'd4, 2'b01, eb);
    do_write(32'h100, 3, 3'd4, 2'b01, 4'h5, 1'b0);
    checks++; if (o_bresp !== 2'b00 || o_bid !== 4'h5 || eb !== 2'b00) begin failures++;
      $display("FAIL incr_bresp got=%b/%h exp=00/5", o_bresp, o_bid); end
    checks++; if (o_wlat !== 1'b1 || o_blat !== 1'b1 || o_bhold !== 1'b1) begin failures++;
      $display("FAIL incr_wlatency got=w%b_b%b_hold%b exp=w1_b1_hold1", o_wlat, o_blat, o_bhold); end
    exp_read(32'h100, 3, 3'd4, 2'b01);
    do_read(32'h100, 3, 3'd4, 2'b01, 4'hA, 1);
    checks++; if (o_rlat !== 1'b1 || o_rhold !== 1'b1) begin failures++;
      $display("FAIL incr_rlatency got=lat%b_hold%b exp=lat1_hold1", o_rlat, o_rhold); end
    for (int i = 0; i <= 3; i++) begin
      checks++;
      if (rd[i] !== wd[i] || rr[i] !== 2'b00 || rl[i] !== (i == 3) || ri[i] !== 4'hA) begin failures++;
        $display("FAIL incr_beat%0d got=%h/%b/%b/%h exp=%h/00/%b/a", i, rd[i], rr[i], rl[i], ri[i], wd[i], (i == 3)); end
    end
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin failures++;
      $display("FAIL incr_rdone got=rvalid%b_arready%b exp=rvalid0_arready1", s_axi_rvalid, s_axi_arready); end
  endtask

  task automatic test_strobe();
    logic [1:0] eb;
    logic [DW-1:0] expv;
    expv = {{96{1'b1}}, 32'h0};
    wd[0] = '1; ws[0] = '1; wl[0] = 1'b1;
    mdl_write(32'h200, 0, 3'd4, 2'b01, eb);
    do_write(32'h200, 0, 3'd4, 2'b01, 4'h1, 1'b0);
    wd[0] = '0; ws[0] = 16'h000F; wl[0] = 1'b1;
    mdl_write(32'h200, 0, 3'd4, 2'b01, eb);
    do_write(32'h200, 0, 3'd4, 2'b01, 4'h2, 1'b0);
    do_read(32'h200, 0, 3'd4, 2'b01, 4'h3, 0);
    checks++; if (rd[0] !== expv || rr[0] !== 2'b00 || rl[0] !== 1'b1) begin failures++;
      $display("FAIL strobe_data got=%h/%b/%b exp=%h/00/1", rd[0], rr[0], rl[0], expv); end
  endtask

  task automatic test_errors();
    logic [1:0] eb;
    logic [AW-1:0] a;
    logic [2:0] sz;
    logic [1:0] bt;
    // out-of-range read, address-wrap read, bad-size read
    for (int t = 0; t < 3; t++) begin
      a  = (t == 0) ? AW'(DEPTH * NB) : (t == 1) ? 32'hFFFF_FFF0 : 32'h40;
      sz = (t == 2) ? 3'd3 : 3'd4;
      exp_read(a, (t == 1) ? 2 : 1, sz, 2'b01);
      do_read(a, (t == 1) ? 2 : 1, sz, 2'b01, 4'h7, 2);
      for (int i = 0; i <= ((t == 1) ? 2 : 1); i++) begin
        checks++;
        if (rd[i] !== er_d[i] || rr[i] !== er_r[i] || rl[i] !== (i == ((t == 1) ? 2 : 1))) begin failures++;
          $display("FAIL err_read t=%0d beat=%0d got=%h/%b/%b exp=%h/%b", t, i, rd[i], rr[i], rl[i], er_d[i], er_r[i]); end
      end
    end
    checks++; if (er_r[0] !== 2'b10) begin failures++;
      $display("FAIL err_model_size got=%b exp=10", er_r[0]); end
    // WRAP burst, bad size, and a burst running off the end of memory
    for (int t = 0; t < 3; t++) begin
      a  = (t == 2) ? AW'((DEPTH - 1) * NB) : 32'h400;
      sz = (t == 1) ? 3'd2 : 3'd4;
      bt = (t == 0) ? 2'b10 : 2'b01;
      for (int j = 0; j < 4; j++) begin
        wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = '1; wl[j] = (j == 3);
      end
      mdl_write(a, 3, sz, bt, eb);
      do_write(a, 3, sz, bt, 4'h9, 1'b1);
      checks++; if (o_bresp !== eb || o_bresp !== ((t == 2) ? 2'b11 : 2'b10)) begin failures++;
        $display("FAIL err_write t=%0d got=%b exp=%b", t, o_bresp, eb); end
    end
    exp_read(32'h400, 3, 3'd4, 2'b01);
    do_read(32'h400, 3, 3'd4, 2'b01, 4'h2, 0);
    for (int i = 0; i <= 3; i++) begin
      checks++; if (rd[i] !== er_d[i] || rr[i] !== 2'b00) begin failures++;
        $display("FAIL err_unchanged beat=%0d got=%h/%b exp=%h/00", i, rd[i], rr[i], er_d[i]); end
    end
    exp_read(AW'((DEPTH - 1) * NB), 0, 3'd4, 2'b01);
    do_read(AW'((DEPTH - 1) * NB), 0, 3'd4, 2'b01, 4'h2, 0);
    checks++; if (rd[0] !== er_d[0] || rr[0] !== 2'b00) begin failures++;
      $display("FAIL err_lastword got=%h/%b exp=%h/00", rd[0], rr[0], er_d[0]); end
  endtask

  task automatic test_wlast();
    logic [1:0] eb;
    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < 4; j++) begin
        wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = '1;
        wl[j] = (t == 0) ? (j == 2) : 1'b0;
      end
      mdl_write(32'h600, 3, 3'd4, 2'b01, eb);
      do_write(32'h600, 3, 3'd4, 2'b01, 4'h4, 1'b0);
      checks++; if (o_bresp !== 2'b10 || eb !== 2'b10 || o_blat !== 1'b1) begin failures++;
        $display("FAIL wlast t=%0d got=%b_lat%b exp=10_lat1", t, o_bresp, o_blat); end
    end
    exp_read(32'h600, 3, 3'd4, 2'b01);
    do_read(32'h600, 3, 3'd4, 2'b01, 4'h4, 0);
    for (int i = 0; i <= 3; i++) begin
      checks++; if (rd[i] !== er_d[i] || rl[i] !== (i == 3)) begin failures++;
        $display("FAIL wlast_data beat=%0d got=%h/%b exp=%h/%b", i, rd[i], rl[i], er_d[i], (i == 3)); end
    end
  endtask

  // Write and read of the same word accepted on one edge: read sees the old word.
  task automatic test_simul();
    logic [DW-1:0] oldv, newv;
    oldv = mdl[16'h30];
    newv = {$urandom, $urandom, $urandom, $urandom};
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h300; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd4; s_axi_awburst = 2'b01; s_axi_awid = 4'h6;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = newv; s_axi_wstrb = '1; s_axi_wlast = 1'b1;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h300; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd4; s_axi_arburst = 2'b01; s_axi_arid = 4'h8;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== oldv) begin failures++;
      $display("FAIL simul_old got=%b/%h exp=1/%h", s_axi_rvalid, s_axi_rdata, oldv); end
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin failures++;
      $display("FAIL simul_b got=%b/%b exp=1/00", s_axi_bvalid, s_axi_bresp); end
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    mdl[16'h30] = newv;
    do_read(32'h300, 0, 3'd4, 2'b01, 4'h8, 0);
    checks++; if (rd[0] !== newv) begin failures++;
      $display("FAIL simul_new got=%h exp=%h", rd[0], newv); end
  endtask

  // Both channels busy at once on disjoint words.
  task automatic test_concurrent();
    logic [1:0] eb;
    for (int j = 0; j < 8; j++) begin
      wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = 16'($urandom); wl[j] = (j == 7);
    end
    exp_read(32'h1000, 7, 3'd4, 2'b01);
    mdl_write(32'h2000, 7, 3'd4, 2'b01, eb);
    fork
      do_write(32'h2000, 7, 3'd4, 2'b01, 4'hC, 1'b1);
      do_read(32'h1000, 7, 3'd4, 2'b01, 4'hD, 2);
    join
    checks++; if (o_bresp !== eb || o_bid !== 4'hC) begin failures++;
      $display("FAIL conc_b got=%b/%h exp=%b/c", o_bresp, o_bid, eb); end
    for (int i = 0; i <= 7; i++) begin
      checks++; if (rd[i] !== er_d[i] || rr[i] !== 2'b00 || ri[i] !== 4'hD || rl[i] !== (i == 7)) begin failures++;
        $display("FAIL conc_r beat=%0d got=%h/%b/%h exp=%h/00/d", i, rd[i], rr[i], ri[i], er_d[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] eb, bt;
    logic [AW-1:0] a;
    logic [2:0] sz;
    logic [IW-1:0] id;
    int len, sel;
    for (int it = 0; it < 40; it++) begin
      a = AW'($urandom_range(0, DEPTH + 4)) * AW'(NB);
      if ($urandom_range(0, 3) == 0) a = a + AW'($urandom_range(0, 15));
      len = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      bt = (sel < 6) ? 2'b01 : (sel < 9) ? 2'b00 : 2'($urandom_range(2, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      id = IW'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j <= len; j++) begin
          wd[j] = {$urandom, $urandom, $urandom, $urandom}; ws[j] = 16'($urandom); wl[j] = (j == len);
        end
        if ($urandom_range(0, 7) == 0) begin
          sel = $urandom_range(0, len);
          wl[sel] = ~wl[sel];
        end
        mdl_write(a, len, sz, bt, eb);
        do_write(a, len, sz, bt, id, 1'b1);
        checks++; if (o_bresp !== eb || o_bid !== id || o_bhold !== 1'b1) begin failures++;
          $display("FAIL rnd_write it=%0d got=%b/%h/hold%b exp=%b/%h/hold1", it, o_bresp, o_bid, o_bhold, eb, id); end
      end else begin
        exp_read(a, len, sz, bt);
        do_read(a, len, sz, bt, id, 2);
        for (int i = 0; i <= len; i++) begin
          checks++;
          if (rd[i] !== er_d[i] || rr[i] !== er_r[i] || rl[i] !== (i == len) || ri[i] !== id) begin failures++;
            $display("FAIL rnd_read it=%0d beat=%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h",
                     it, i, rd[i], rr[i], rl[i], ri[i], er_d[i], er_r[i], (i == len), id); end
        end
        checks++; if (o_rhold !== 1'b1) begin failures++;
          $display("FAIL rnd_hold it=%0d got=%b exp=1", it, o_rhold); end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_read(32'h800, 7, 3'd4, 2'b01);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h800; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd4; s_axi_arburst = 2'b01; s_axi_arid = 4'h3;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    tick();
    tick();
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== er_d[2]) begin failures++;
      $display("FAIL rstmid_beat2 got=%b/%h exp=1/%h", s_axi_rvalid, s_axi_rdata, er_d[2]); end
    #2 rst = 1'b1;
    s_axi_rready = 1'b0;
    #1;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || s_axi_rlast !== 1'b0 || s_axi_rdata !== '0) begin
      failures++;
      $display("FAIL rstmid_state got=rvalid%b_arready%b_rlast%b_rdata%h exp=rvalid0_arready1_rlast0_rdata0",
               s_axi_rvalid, s_axi_arready, s_axi_rlast, s_axi_rdata); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_read(32'h800, 7, 3'd4, 2'b01, 4'h3, 0);
    for (int i = 0; i <= 7; i++) begin
      checks++; if (rd[i] !== er_d[i] || rr[i] !== 2'b00 || rl[i] !== (i == 7)) begin failures++;
        $display("FAIL rstmid_intact beat=%0d got=%h/%b/%b exp=%h/00/%b", i, rd[i], rr[i], rl[i], er_d[i], (i == 7)); end
    end
  endtask

  initial begin
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; s_axi_wlast = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    test_reset();
    test_preload();
    test_incr_burst();
    test_strobe();
    test_errors();
    test_wlast();
    test_simul();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
